wspr_fsk_nco: RTL



---
 rtl/wspr_fsk_nco_if.sv | 28 ++
 rtl/wspr_fsk_nco.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wspr_fsk_nco_if.sv
// Symbol, configuration and RF-output bundle of the WSPR 4-FSK NCO.
// The master drives configuration and symbols, and the slave (the NCO)
// returns the handshake and the carrier/status outputs.
interface wspr_fsk_nco_if #(
  parameter int ACC_W = 32
);
  logic [ACC_W-1:0] base_fcw;
  logic [15:0]      step_fcw;
  logic             start;
  logic [1:0]       sym_in;
  logic             sym_valid;
  logic             sym_ready;
  logic             rf_out;
  logic [ACC_W-1:0] tone_fcw;
  logic             busy;
  logic             done;
  logic             underrun;

  modport master (
    output base_fcw, step_fcw, start, sym_in, sym_valid,
    input  sym_ready, rf_out, tone_fcw, busy, done, underrun
  );

  modport slave (
    input  base_fcw, step_fcw, start, sym_in, sym_valid,
    output sym_ready, rf_out, tone_fcw, busy, done, underrun
  );
endinterface

// File: rtl/wspr_fsk_nco.sv
// WSPR 4-FSK phase-accumulator NCO.
// Pulls 2-bit channel symbols through a one-entry buffer, holds each one for
// SYM_PERIOD clocks and emits the accumulator MSB as a square-wave carrier.
// Phase is never reset at symbol changes, so the carrier stays continuous.
//
//   state | meaning
//   IDLE  | carrier off, accumulator and tone cleared, waiting for start
//   PRIME | frame armed, waiting for the first symbol (no timeout)
//   RUN   | transmitting; one-entry lookahead buffer refilled between boundaries
module wspr_fsk_nco #(
  parameter int ACC_W      = 32,
  parameter int SYM_PERIOD = 6826667,
  parameter int NUM_SYMS   = 162,
  parameter int CNT_W      = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wspr_fsk_nco_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SYM_PERIOD - 1);
  localparam logic [7:0]       LAST_IDX   = 8'(NUM_SYMS - 1);

  state_t           state;
  logic [1:0]       nxt_sym;
  logic             nxt_full;
  logic [7:0]       sym_idx;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] tone_q;
  logic             busy_q;
  logic             done_q;
  logic             underrun_q;
  logic             ready;

  // The registered tone word doubles as the current-symbol register: it is
  // reloaded on exactly the edges where the current symbol changes.
  function automatic logic [ACC_W-1:0] tone_of(input logic [1:0] sym);
    return bus.base_fcw + (ACC_W'(bus.step_fcw) * ACC_W'(sym));
  endfunction

  // Ready depends on registered state only, never on sym_valid.
  always_comb begin
    ready = 1'b0;
    if (state == PRIME)
      ready = 1'b1;
    else if (state == RUN)
      ready = !nxt_full;
  end

  // Sequencer, symbol buffer, period timer and phase accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nxt_sym    <= '0;
      nxt_full   <= 1'b0;
      sym_idx    <= '0;
      cnt        <= '0;
      acc        <= '0;
      tone_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          acc    <= '0;
          tone_q <= '0;
          busy_q <= 1'b0;
          if (bus.start) begin
            underrun_q <= 1'b0;
            nxt_full   <= 1'b0;
            busy_q     <= 1'b1;
            state      <= PRIME;
          end
        end

        PRIME: begin
          if (bus.sym_valid) begin
            tone_q  <= tone_of(bus.sym_in);
            sym_idx <= '0;
            cnt     <= CNT_RELOAD;
            state   <= RUN;
          end
        end

        RUN: begin
          acc <= acc + tone_q;
          if (bus.sym_valid && ready) begin
            nxt_sym  <= bus.sym_in;
            nxt_full <= 1'b1;
          end
          if (cnt == '0) begin
            if (sym_idx == LAST_IDX) begin
              // Frame complete: anything still buffered belongs to no frame.
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              acc      <= '0;
              tone_q   <= '0;
              nxt_full <= 1'b0;
              state    <= IDLE;
            end else if (nxt_full) begin
              tone_q   <= tone_of(nxt_sym);
              nxt_full <= 1'b0;
              sym_idx  <= sym_idx + 8'd1;
              cnt      <= CNT_RELOAD;
            end else if (bus.sym_valid) begin
              // Symbol arriving right on the boundary goes straight to air
              // instead of through the buffer.
              tone_q   <= tone_of(bus.sym_in);
              nxt_full <= 1'b0;
              sym_idx  <= sym_idx + 8'd1;
              cnt      <= CNT_RELOAD;
            end else begin
              underrun_q <= 1'b1;
              busy_q     <= 1'b0;
              acc        <= '0;
              tone_q     <= '0;
              state      <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.sym_ready = ready;
  assign bus.rf_out    = acc[ACC_W-1];
  assign bus.tone_fcw  = tone_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.underrun  = underrun_q;

endmodule
